weight_fetch_sequencer: RTL and testbench

Drives the read port of the weight memory and streams the returned weight words to the convolution MAC stage over a valid/ready interface. A layer controller issues a base address and a word count with a one-cycle `start`. The block then performs sequential reads, compensates for the memory's one-cycle read latency, and absorbs consumer backpressure in a 2-entry buffer. It sits between the weight memory (upstream) and the feature-extractor MAC array (downstream).

---
 rtl/weight_fetch_pkg.sv | 14 +
 rtl/weight_skid_fifo.sv | 72 +++++++
 rtl/weight_fetch_sequencer.sv | 116 +++++++++++
 tb/tb_weight_fetch_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_fetch_pkg.sv
// Shared types and sizing for the weight fetch sequencer and its output buffer.
package weight_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      DONE
   } state_t;

   localparam int unsigned BUF_DEPTH = 2;
   localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry {last, data} buffer; the head entry is a register that drives the output directly.
module weight_skid_fifo
   import weight_fetch_pkg::*;
#(
   parameter int unsigned DWIDTH = 72
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DWIDTH-1:0] push_data_i,
   input  logic              push_last_i,
   input  logic              pop_i,
   output logic [OCC_W-1:0]  occ_o,
   output logic              valid_o,
   output logic [DWIDTH-1:0] head_data_o,
   output logic              head_last_o
);

   logic [DWIDTH:0]  head_q, head_d;
   logic [DWIDTH:0]  tail_q, tail_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic [DWIDTH:0]  entry;
   logic             pop_ok;

   assign entry  = {push_last_i, push_data_i};
   assign pop_ok = pop_i && (occ_q != '0);

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      case ({push_i, pop_ok})
         2'b10: begin
            if (occ_q == '0) head_d = entry;
            else             tail_d = entry;
            occ_d = occ_q + 1'b1;
         end
         2'b01: begin
            head_d = tail_q;
            occ_d  = occ_q - 1'b1;
         end
         2'b11: begin
            // With one entry the new word becomes head; with two it shifts in behind.
            if (occ_q == OCC_W'(1)) begin
               head_d = entry;
            end else begin
               head_d = tail_q;
               tail_d = entry;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   assign occ_o       = occ_q;
   assign valid_o     = (occ_q != '0);
   assign head_data_o = head_q[DWIDTH-1:0];
   assign head_last_o = head_q[DWIDTH];

endmodule

// File: rtl/weight_fetch_sequencer.sv
// Issues sequential weight-memory reads for a job and streams the words out over valid/ready.
module weight_fetch_sequencer
   import weight_fetch_pkg::*;
#(
   parameter int unsigned AWIDTH = 16,
   parameter int unsigned DWIDTH = 72,
   parameter int unsigned CWIDTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AWIDTH-1:0] base_addr,
   input  logic [CWIDTH-1:0] num_words,
   output logic              busy,
   output logic              done,
   output logic              mem_read,
   output logic [AWIDTH-1:0] mem_addr,
   input  logic [DWIDTH-1:0] mem_dout,
   output logic              w_valid,
   output logic [DWIDTH-1:0] w_data,
   output logic              w_last,
   input  logic              w_ready
);

   state_t            state_q, state_d;
   logic [AWIDTH-1:0] base_q, base_d;
   logic [CWIDTH-1:0] num_q, num_d;
   logic [CWIDTH-1:0] issued_q, issued_d;
   logic              inflight_q, inflight_last_q;
   logic [OCC_W-1:0]  occ;
   logic              pop;
   logic              credit_ok;
   logic              last_issue;

   assign pop        = w_valid && w_ready;
   assign last_issue = (issued_q == num_q - 1'b1);
   // Buffer slots already spoken for (held + returning) must leave room after this cycle's pop.
   assign credit_ok  = ({1'b0, occ} + (OCC_W+1)'(inflight_q))
                       < ((OCC_W+1)'(BUF_DEPTH) + (OCC_W+1)'(pop));
   assign mem_addr   = base_q + AWIDTH'(issued_q);

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      num_d    = num_q;
      issued_d = issued_q;
      mem_read = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (num_words == '0) begin
                  state_d = DONE;
               end else begin
                  base_d   = base_addr;
                  num_d    = num_words;
                  issued_d = '0;
                  state_d  = FETCH;
               end
            end
         end
         FETCH: begin
            busy = 1'b1;
            if (credit_ok) begin
               mem_read = 1'b1;
               issued_d = issued_q + 1'b1;
               if (last_issue) state_d = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (pop && w_last) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         base_q          <= '0;
         num_q           <= '0;
         issued_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         base_q          <= base_d;
         num_q           <= num_d;
         issued_q        <= issued_d;
         inflight_q      <= mem_read;
         inflight_last_q <= mem_read && last_issue;
      end
   end

   weight_skid_fifo #(
      .DWIDTH (DWIDTH)
   ) u_buf (
      .clk         (clk),
      .rst         (rst),
      .push_i      (inflight_q),
      .push_data_i (mem_dout),
      .push_last_i (inflight_last_q),
      .pop_i       (pop),
      .occ_o       (occ),
      .valid_o     (w_valid),
      .head_data_o (w_data),
      .head_last_o (w_last)
   );

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Self-checking bench for weight_fetch_sequencer: scoreboard of expected words plus directed timing checks.
module tb_weight_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] base_addr = '0;
   logic [15:0] num_words = '0;
   logic        busy, done, mem_read, w_valid, w_last;
   logic [15:0] mem_addr;
   logic [71:0] mem_dout = '0;
   logic [71:0] w_data;
   logic        w_ready = 1'b1;
   bit          ready_rand = 1'b0;

   typedef struct {
      logic [71:0] data;
      logic        last;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_acc   = 0;
   int   n_done  = 0;
   int   occ_m   = 0;
   int   infl_m  = 0;
   bit   stall_prev = 1'b0;
   bit   lastf_prev = 1'b0;
   bit   last_hs_prev = 1'b0;
   logic [71:0] data_prev = '0;

   weight_fetch_sequencer #(
      .AWIDTH (16),
      .DWIDTH (72),
      .CWIDTH (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .num_words (num_words),
      .busy      (busy),
      .done      (done),
      .mem_read  (mem_read),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout),
      .w_valid   (w_valid),
      .w_data    (w_data),
      .w_last    (w_last),
      .w_ready   (w_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [71:0] word_of(input logic [15:0] a);
      return {a, 40'hC0FFEE1234, ~a};
   endfunction

   // Weight memory with one-cycle read latency.
   always @(posedge clk) begin
      if (mem_read) mem_dout <= word_of(mem_addr);
   end

   always @(posedge clk) begin
      #1;
      w_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [15:0] b, input logic [15:0] n);
      for (int unsigned i = 0; i < n; i++) begin
         exp_t e;
         e.data = word_of(16'(b + i));
         e.last = (i == n - 1);
         sb.push_back(e);
      end
      start     = 1'b1;
      base_addr = b;
      num_words = n;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int unsigned budget);
      bit seen = 1'b0;
      for (int unsigned i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check_eq("done_timeout", 72'(seen), 72'(1));
   endtask

   // Consumer-side monitor: scoreboard pops, buffer-occupancy model and stall stability.
   always @(negedge clk) begin
      bit pop_tb;
      exp_t e;
      pop_tb = w_valid && w_ready;
      if (rst) begin
         occ_m        = 0;
         infl_m       = 0;
         stall_prev   = 1'b0;
         last_hs_prev = 1'b0;
      end else begin
         check_eq("valid_vs_occ", 72'(w_valid), 72'(occ_m != 0));
         if (stall_prev) begin
            check_eq("stall_valid", 72'(w_valid), 72'(1));
            check_eq("stall_data", w_data, data_prev);
            check_eq("stall_last", 72'(w_last), 72'(lastf_prev));
         end
         if (mem_read)
            check_eq("credit", 72'((occ_m + infl_m) < (2 + int'(pop_tb))), 72'(1));
         if (last_hs_prev) check_eq("done_after_last", 72'(done), 72'(1));
         if (done) n_done++;
         if (pop_tb) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_word", 72'(1), 72'(0));
            end else begin
               e = sb.pop_front();
               check_eq("word_data", w_data, e.data);
               check_eq("word_last", 72'(w_last), 72'(e.last));
            end
            n_acc++;
         end
         occ_m        = occ_m + infl_m - int'(pop_tb);
         infl_m       = int'(mem_read);
         stall_prev   = w_valid && !w_ready;
         data_prev    = w_data;
         lastf_prev   = w_last;
         last_hs_prev = pop_tb && w_last;
      end
   end

   initial begin
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_busy", 72'(busy), 72'(0));
      check_eq("rst_done", 72'(done), 72'(0));
      check_eq("rst_rd", 72'(mem_read), 72'(0));
      check_eq("rst_addr", 72'(mem_addr), 72'(0));
      check_eq("rst_valid", 72'(w_valid), 72'(0));
      check_eq("rst_last", 72'(w_last), 72'(0));
      check_eq("rst_data", w_data, 72'(0));
      tick();

      // Basic: N=4 at 0x0010, consumer always ready.
      start_job(16'h0010, 16'd4);
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(negedge clk);
         check_eq("basic_rd", 72'(mem_read), 72'(cyc <= 4));
         if (cyc <= 4) check_eq("basic_addr", 72'(mem_addr), 72'(16'(16'h10 + cyc - 1)));
         check_eq("basic_valid", 72'(w_valid), 72'(cyc >= 3 && cyc <= 6));
         if (cyc >= 3 && cyc <= 6) begin
            check_eq("basic_data", w_data, word_of(16'(16'h10 + cyc - 3)));
            check_eq("basic_last", 72'(w_last), 72'(cyc == 6));
         end
         check_eq("basic_done", 72'(done), 72'(cyc == 7));
         check_eq("basic_busy", 72'(busy), 72'(cyc <= 6));
      end
      tick();
      check_eq("basic_drained", 72'(sb.size()), 72'(0));

      // Zero count.
      start_job(16'h0055, 16'd0);
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clk);
         check_eq("zero_done", 72'(done), 72'(cyc == 1));
         check_eq("zero_rd", 72'(mem_read), 72'(0));
         check_eq("zero_valid", 72'(w_valid), 72'(0));
         check_eq("zero_busy", 72'(busy), 72'(0));
      end
      tick();

      // Address wrap-around.
      start_job(16'hFFFE, 16'd4);
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clk);
         check_eq("wrap_rd", 72'(mem_read), 72'(1));
         check_eq("wrap_addr", 72'(mem_addr), 72'(16'(16'hFFFE + cyc - 1)));
      end
      wait_done(50);
      tick();
      check_eq("wrap_drained", 72'(sb.size()), 72'(0));

      // Random backpressure.
      n_acc      = 0;
      ready_rand = 1'b1;
      start_job(16'h0040, 16'd8);
      wait_done(400);
      ready_rand = 1'b0;
      tick();
      check_eq("bp_count", 72'(n_acc), 72'(8));
      check_eq("bp_drained", 72'(sb.size()), 72'(0));

      // Reset in cycle 4 of an N=16 job, then a fresh N=2 job.
      start_job(16'h0100, 16'd16);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      check_eq("mid_busy", 72'(busy), 72'(0));
      check_eq("mid_done", 72'(done), 72'(0));
      check_eq("mid_rd", 72'(mem_read), 72'(0));
      check_eq("mid_addr", 72'(mem_addr), 72'(0));
      check_eq("mid_valid", 72'(w_valid), 72'(0));
      check_eq("mid_last", 72'(w_last), 72'(0));
      check_eq("mid_data", w_data, 72'(0));
      tick();
      n_acc = 0;
      start_job(16'h0200, 16'd2);
      wait_done(50);
      repeat (4) tick();
      check_eq("post_rst_count", 72'(n_acc), 72'(2));
      check_eq("post_rst_drained", 72'(sb.size()), 72'(0));

      // Second start while busy is ignored.
      n_acc  = 0;
      n_done = 0;
      start_job(16'h0300, 16'd6);
      start     = 1'b1;
      base_addr = 16'h0900;
      num_words = 16'd3;
      tick();
      start = 1'b0;
      wait_done(100);
      repeat (8) tick();
      check_eq("busy_start_words", 72'(n_acc), 72'(6));
      check_eq("busy_start_dones", 72'(n_done), 72'(1));
      check_eq("busy_start_drained", 72'(sb.size()), 72'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
